// File: rtl/fp_add_pipe.sv
// Four-stage pipelined floating-point adder/subtractor: decode/swap, align,
// add/leading-zero count, normalize/round/pack. Denormal inputs flush to zero.
module fp_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clock_80,
    input  logic                   reset_n_80,
    input  logic                   in_valid_80,
    input  logic                   op_sub_80,
    input  logic [EXP_W+MAN_W:0]   input_1_80,
    input  logic [EXP_W+MAN_W:0]   input_2_80,
    output logic                   out_valid_80,
    output logic [EXP_W+MAN_W:0]   sum_80,
    output logic                   overflow_80,
    output logic                   underflow_80,
    output logic                   zero_80,
    output logic                   invalid_80
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;           // significand with hidden bit
    localparam int ALN_W = MAN_W + 4;           // significand plus guard/round/sticky
    localparam int SUM_W = ALN_W + 1;           // plus carry-out
    localparam int LZ_W  = $clog2(ALN_W + 1);
    localparam int XW    = EXP_W + 2;           // signed exponent work width
    localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic         hit;
        logic [W-1:0] res;
        logic         inv;
        logic         zero;
    } spec_t;

    function automatic logic [LZ_W-1:0] count_lz(input logic [ALN_W-1:0] v);
        count_lz = LZ_W'(ALN_W);
        for (int i = 0; i < ALN_W; i++)
            if (v[i]) count_lz = LZ_W'(ALN_W - 1 - i);
    endfunction

    // ---------------- S1: decode, special detect, swap ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
    spec_t            spec_d;

    assign a_sign = input_1_80[W-1];
    assign b_sign = input_2_80[W-1] ^ op_sub_80;
    assign a_exp  = input_1_80[W-2 -: EXP_W];
    assign b_exp  = input_2_80[W-2 -: EXP_W];
    assign a_frac = input_1_80[MAN_W-1:0];
    assign b_frac = input_2_80[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    assign swap   = {b_exp, b_frac} > {a_exp, a_frac};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        spec_d = '{hit: 1'b1, res: '0, inv: 1'b0, zero: 1'b0};
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            spec_d.res = QNAN;
            spec_d.inv = 1'b1;
        end else if (a_inf) begin
            spec_d.res = {a_sign, a_exp, a_frac};
        end else if (b_inf) begin
            spec_d.res = {b_sign, b_exp, b_frac};
        end else if (a_zero && b_zero) begin
            spec_d.res  = {a_sign & b_sign, {(W-1){1'b0}}};
            spec_d.zero = 1'b1;
        end else if (a_zero) begin
            spec_d.res = {b_sign, b_exp, b_frac};
        end else if (b_zero) begin
            spec_d.res = {a_sign, a_exp, a_frac};
        end else begin
            spec_d.hit = 1'b0;
        end
    end

    logic [2:0] vld;

    always_ff @(posedge clock_80 or negedge reset_n_80) begin
        if (!reset_n_80) vld <= '0;
        else             vld <= {vld[1:0], in_valid_80};
    end

    // NOTE: datapath stages carry no reset; their contents only reach the outputs
    // alongside a stage valid bit, and those valid bits are reset.
    logic             s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [SIG_W-1:0] s1_big, s1_small;
    spec_t            s1_spec;

    always_ff @(posedge clock_80) begin
        s1_sign  <= swap ? b_sign : a_sign;
        s1_exp   <= swap ? b_exp : a_exp;
        s1_big   <= {1'b1, swap ? b_frac : a_frac};
        s1_small <= {1'b1, swap ? a_frac : b_frac};
        s1_diff  <= swap ? b_exp - a_exp : a_exp - b_exp;
        s1_sub   <= a_sign ^ b_sign;
        s1_spec  <= spec_d;
    end

    // ---------------- S2: align smaller operand ----------------
    logic [2*ALN_W-1:0] wide;
    logic [ALN_W-1:0]   small_al;

    always_comb begin
        wide = {s1_small, 3'b000, {ALN_W{1'b0}}} >> s1_diff;
        if (int'(s1_diff) > MAN_W + 3)
            small_al = {{(ALN_W-1){1'b0}}, 1'b1};
        else
            small_al = {wide[2*ALN_W-1:ALN_W+1], wide[ALN_W] | (|wide[ALN_W-1:0])};
    end

    logic             s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [ALN_W-1:0] s2_big, s2_small;
    spec_t            s2_spec;

    always_ff @(posedge clock_80) begin
        s2_sign  <= s1_sign;
        s2_sub   <= s1_sub;
        s2_exp   <= s1_exp;
        s2_big   <= {s1_big, 3'b000};
        s2_small <= small_al;
        s2_spec  <= s1_spec;
    end

    // ---------------- S3: add / subtract, leading-zero count ----------------
    logic [SUM_W-1:0] sum_d;

    assign sum_d = s2_sub ? {1'b0, s2_big} - {1'b0, s2_small}
                          : {1'b0, s2_big} + {1'b0, s2_small};

    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [SUM_W-1:0] s3_sum;
    logic [LZ_W-1:0]  s3_lz;
    spec_t            s3_spec;

    always_ff @(posedge clock_80) begin
        s3_sign <= s2_sign;
        s3_exp  <= s2_exp;
        s3_sum  <= sum_d;
        s3_lz   <= count_lz(sum_d[ALN_W-1:0]);
        s3_spec <= s2_spec;
    end

    // ---------------- S4: normalize, round, pack ----------------
    logic [ALN_W-1:0]       norm;
    logic [SIG_W-1:0]       mant;
    logic [SIG_W:0]         mant_r;
    logic [MAN_W-1:0]       frac_r;
    logic                   rnd;
    logic signed [XW-1:0]   exp_n, exp_r;
    logic [W-1:0]           res;
    logic                   res_ovf, res_unf, res_zero, res_inv;

    always_comb begin
        if (s3_sum[SUM_W-1]) begin
            norm  = {s3_sum[SUM_W-1:2], s3_sum[1] | s3_sum[0]};
            exp_n = $signed({2'b00, s3_exp} + XW'(1));
        end else begin
            norm  = s3_sum[ALN_W-1:0] << s3_lz;
            exp_n = $signed({2'b00, s3_exp} - {{(XW-LZ_W){1'b0}}, s3_lz});
        end
        mant   = norm[ALN_W-1:3];
        rnd    = norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r = {1'b0, mant} + {{SIG_W{1'b0}}, rnd};
        frac_r = mant_r[SIG_W] ? mant_r[SIG_W-1:1] : mant_r[MAN_W-1:0];
        exp_r  = exp_n + $signed({{(XW-1){1'b0}}, mant_r[SIG_W]});

        res      = {s3_sign, exp_r[EXP_W-1:0], frac_r};
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_zero = 1'b0;
        res_inv  = 1'b0;
        if (s3_spec.hit) begin
            res      = s3_spec.res;
            res_inv  = s3_spec.inv;
            res_zero = s3_spec.zero;
        end else if (s3_sum == '0) begin
            res      = '0;
            res_zero = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            // Underflow always flushes to +0, whatever the sign of the lost value.
            res      = '0;
            res_unf  = 1'b1;
            res_zero = 1'b1;
        end else if (exp_r >= EXP_TOP) begin
            res     = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_ovf = 1'b1;
        end
    end

    always_ff @(posedge clock_80 or negedge reset_n_80) begin
        if (!reset_n_80) begin
            out_valid_80 <= 1'b0;
            sum_80       <= '0;
            overflow_80  <= 1'b0;
            underflow_80 <= 1'b0;
            zero_80      <= 1'b0;
            invalid_80   <= 1'b0;
        end else begin
            out_valid_80 <= vld[2];
            if (vld[2]) begin
                sum_80       <= res;
                overflow_80  <= res_ovf;
                underflow_80 <= res_unf;
                zero_80      <= res_zero;
                invalid_80   <= res_inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: expected results are queued with their due
// cycle at issue time and compared when out_valid_80 presents them.
module tb_fp_add_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;

    // flag order {overflow, underflow, zero, invalid}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_OVF  = 4'b1000;
    localparam logic [3:0] F_UNF  = 4'b0100;
    localparam logic [3:0] F_ZERO = 4'b0010;
    localparam logic [3:0] F_INV  = 4'b0001;

    logic         clock_80 = 1'b0;
    logic         reset_n_80;
    logic         in_valid_80;
    logic         op_sub_80;
    logic [W-1:0] input_1_80, input_2_80;
    logic         out_valid_80;
    logic [W-1:0] sum_80;
    logic         overflow_80, underflow_80, zero_80, invalid_80;

    fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock_80     (clock_80),
        .reset_n_80   (reset_n_80),
        .in_valid_80  (in_valid_80),
        .op_sub_80    (op_sub_80),
        .input_1_80   (input_1_80),
        .input_2_80   (input_2_80),
        .out_valid_80 (out_valid_80),
        .sum_80       (sum_80),
        .overflow_80  (overflow_80),
        .underflow_80 (underflow_80),
        .zero_80      (zero_80),
        .invalid_80   (invalid_80)
    );

    always #5 clock_80 = ~clock_80;

    typedef struct {
        logic [W+3:0] res;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;
    logic         mon_en = 1'b0;
    logic [W+3:0] last_exp = '0;
    logic [W+3:0] obs;

    assign obs = {sum_80, overflow_80, underflow_80, zero_80, invalid_80};

    always @(posedge clock_80) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every valid output, checks latency,
    // and checks that sum/flags hold while out_valid_80 is low.
    always @(negedge clock_80) begin
        if (mon_en) begin
            if (out_valid_80) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result cycle=%0d got=%h required=no output", cyc, obs);
                end else begin
                    mon_e = sb.pop_front();
                    if (obs !== mon_e.res || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL result cycle=%0d got=%h required=%h at cycle %0d",
                                 cyc, obs, mon_e.res, mon_e.due);
                    end
                    last_exp = mon_e.res;
                end
            end else begin
                checks++;
                if (obs !== last_exp) begin
                    errors++;
                    $display("FAIL hold cycle=%0d got=%h required=%h", cyc, obs, last_exp);
                end
                if (sb.size() != 0) begin
                    checks++;
                    if (sb[0].due <= cyc) begin
                        errors++;
                        $display("FAIL missing_result cycle=%0d got=no output required=%h",
                                 cyc, sb[0].res);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    // Called at a falling edge: presents one operation for the next rising edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] s, input logic [3:0] fl);
        input_1_80  = a;
        input_2_80  = b;
        op_sub_80   = sub;
        in_valid_80 = 1'b1;
        sb.push_back('{res: {s, fl}, due: cyc + 4});
        @(negedge clock_80);
    endtask

    task automatic drain();
        in_valid_80 = 1'b0;
        for (int i = 0; i < 16 && sb.size() != 0; i++) @(negedge clock_80);
        @(negedge clock_80);
    endtask

    task automatic test_reset();
        reset_n_80  = 1'b1;
        in_valid_80 = 1'b0;
        op_sub_80   = 1'b0;
        input_1_80  = '0;
        input_2_80  = '0;
        #1 reset_n_80 = 1'b0;
        #1;
        checks++;
        if (out_valid_80 !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL reset_async got valid=%b out=%h required valid=0 out=0", out_valid_80, obs);
        end
        repeat (2) @(negedge clock_80);
        reset_n_80 = 1'b1;
        @(negedge clock_80);
        checks++;
        if (out_valid_80 !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL reset_idle got valid=%b out=%h required valid=0 out=0", out_valid_80, obs);
        end
        last_exp = '0;
        mon_en   = 1'b1;
    endtask

    task automatic test_add();
        drive(16'h3C00, 16'h3C00, 1'b0, 16'h4000, F_NONE);
        drive(16'h3C00, 16'h4000, 1'b0, 16'h4200, F_NONE);
        drive(16'hC000, 16'h3C00, 1'b0, 16'hBC00, F_NONE);
        drive(16'h4900, 16'h4900, 1'b0, 16'h4D00, F_NONE);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL add_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_round();
        drive(16'h3C00, 16'h3C00, 1'b1, 16'h0000, F_ZERO);
        drive(16'h3C00, 16'h1000, 1'b0, 16'h3C00, F_NONE);
        drive(16'h3C01, 16'h1000, 1'b0, 16'h3C02, F_NONE);
        drive(16'h3C00, 16'h1001, 1'b0, 16'h3C01, F_NONE);
        drive(16'h3C00, 16'h0400, 1'b0, 16'h3C00, F_NONE);
        drive(16'h3C00, 16'h0400, 1'b1, 16'h3C00, F_NONE);
        drive(16'h4000, 16'h3C00, 1'b1, 16'h3C00, F_NONE);
        drive(16'h3C00, 16'h4000, 1'b1, 16'hBC00, F_NONE);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL round_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_limits();
        drive(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, F_OVF);
        drive(16'h0400, 16'h0401, 1'b1, 16'h0000, F_UNF | F_ZERO);
        drive(16'h0001, 16'h3C00, 1'b0, 16'h3C00, F_NONE);
        drive(16'h8000, 16'h8000, 1'b0, 16'h8000, F_ZERO);
        drive(16'h8000, 16'h0000, 1'b0, 16'h0000, F_ZERO);
        drive(16'h0000, 16'h0000, 1'b1, 16'h0000, F_ZERO);
        drive(16'h8000, 16'h0000, 1'b1, 16'h8000, F_ZERO);
        drive(16'h0000, 16'h3C00, 1'b1, 16'hBC00, F_NONE);
        drive(16'h83FF, 16'h8000, 1'b0, 16'h8000, F_ZERO);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL limits_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_specials();
        drive(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, F_INV);
        drive(16'h7C01, 16'h3C00, 1'b0, 16'h7E00, F_INV);
        drive(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, F_NONE);
        drive(16'h7C00, 16'h7C00, 1'b0, 16'h7C00, F_NONE);
        drive(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, F_INV);
        drive(16'h3C00, 16'hFC00, 1'b1, 16'h7C00, F_NONE);
        drive(16'h3C00, 16'hFE00, 1'b0, 16'h7E00, F_INV);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL specials_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_flush();
        drive(16'h4900, 16'h4900, 1'b0, 16'h4D00, F_NONE);
        drive(16'h3C00, 16'h3C00, 1'b0, 16'h4000, F_NONE);
        drive(16'h4000, 16'h4000, 1'b0, 16'h4400, F_NONE);
        drive(16'h4400, 16'h3C00, 1'b0, 16'h4500, F_NONE);
        in_valid_80 = 1'b0;
        #2 reset_n_80 = 1'b0;
        #1;
        checks++;
        if (out_valid_80 !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL flush_async got valid=%b out=%h required valid=0 out=0", out_valid_80, obs);
        end
        sb.delete();
        last_exp = '0;
        @(negedge clock_80);
        reset_n_80 = 1'b1;
        repeat (4) @(negedge clock_80);
        drive(16'h4200, 16'h3C00, 1'b0, 16'h4400, F_NONE);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flush_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_gap_pattern();
        logic [W-1:0] ga [4] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4200};
        logic [W-1:0] gb [4] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00};
        logic         gs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] gr [4] = '{16'h4000, 16'h4400, 16'h4500, 16'h4000};
        logic [7:0]   seen = '0;
        logic [7:0]   want = '0;
        for (int j = 0; j < 12; j++) begin
            if (j >= 4) begin
                seen[j-4] = out_valid_80;
                want[j-4] = ((j - 4) % 2 == 0);
            end
            if (j < 8 && (j % 2 == 0)) begin
                drive(ga[j/2], gb[j/2], gs[j/2], gr[j/2], F_NONE);
            end else begin
                in_valid_80 = 1'b0;
                @(negedge clock_80);
            end
        end
        checks++;
        if (seen !== want) begin
            errors++;
            $display("FAIL gap_pattern got=%b required=%b", seen, want);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL gap_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_round();
        test_limits();
        test_specials();
        test_reset_flush();
        test_gap_pattern();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
